cpu_ocimem_access: RTL
======================

# cpu_ocimem_access

Debug-side memory access engine for the Nios II on-chip instrumentation (OCI). It sits directly downstream of the JTAG debug module's system-clock stage:
- It decodes the `jdo` word and the `take_action_ocimem_*` strobes into reads and writes of a 256×32 debug RAM.
- It returns results to the JTAG shift path on `MonDReg`, `monitor_ready` and `monitor_error`.
- A CPU-side slave port shares the same RAM, and debug accesses have priority over it.

## Interface
Parameters:
- `ADDR_W`, 8, word-address width; RAM depth is 2^ADDR_W.
- `DATA_W`, 32, data width; fixed, because the `jdo` field layout depends on it.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset_n`  in  1  reset; synchronous, active-low.
- `jdo`  in  38  command and data word from the JTAG debug module.
- `take_action_ocimem_a`  in  1  strobe: load address, optionally followed by a read.
- `take_action_ocimem_b`  in  1  strobe: write data, then increment the address.
- `take_no_action_ocimem_a`  in  1  strobe: read, then increment the address.
- `cpu_address`  in  ADDR_W  CPU word address.
- `cpu_read`, `cpu_write`  in  1  CPU request.
- `cpu_writedata`  in  32  CPU write data.
- `cpu_readdata`  out  32  CPU read data.
- `cpu_readdatavalid`  out  1  CPU read data qualifier.
- `cpu_waitrequest`  out  1  CPU stall.
- `MonDReg`  out  32  debug data register.
- `monitor_ready`  out  1  last debug command complete.
- `monitor_error`  out  1  sticky error flag.

## Operation
`jdo` fields:
- `[33:26]`: address.
- `[34:3]`: write data, used by `take_action_ocimem_b`.
- `[35]`: read-after-load, used by `take_action_ocimem_a`.
- `[36]`: clear-error, used by `take_action_ocimem_a`.

Internal state:
- Address register `MonAReg` is `ADDR_W` bits.
- Address increments wrap from 255 to 0.

FSM states are IDLE, DRD_ISSUE, DRD_CAP, DWR and CRD_CAP.

From IDLE:
- On `take_action_ocimem_a`:
  - `MonAReg` is loaded from `jdo[33:26]`.
  - If `jdo[36]` is set, `monitor_error` clears.
  - If `jdo[35]` is set, the FSM goes to DRD_ISSUE. Otherwise `monitor_ready` is set to 1 and the FSM stays in IDLE.
- On `take_action_ocimem_b`: `MonDReg` is loaded from `jdo[34:3]` and the FSM goes to DWR.
- On `take_no_action_ocimem_a`: the FSM goes to DRD_ISSUE.
- On any of these strobes, `monitor_ready` clears.

Debug paths:
- DWR: the RAM is written with `MonDReg` at `MonAReg`, `MonAReg` increments, `monitor_ready` is set to 1, and the FSM returns to IDLE.
- DRD_ISSUE: the RAM is read at `MonAReg` and the FSM goes to DRD_CAP.
- DRD_CAP: `MonDReg` is loaded from RAM data, `monitor_ready` is set to 1, and the FSM returns to IDLE.
  - `MonAReg` increments only for `take_no_action_ocimem_a`, which is remembered in a flag.

CPU path:
- Accepted only in IDLE with no debug strobe in the same cycle.
- `cpu_waitrequest` is 1 when the FSM is not IDLE or any debug strobe is high. It is combinational.
- An accepted write commits in the same cycle.
- An accepted read goes to CRD_CAP. There `cpu_readdata` is loaded, `cpu_readdatavalid` is 1 for exactly one cycle, and the FSM returns to IDLE.

Boundary behaviour:
- Several strobes in one cycle: priority is `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`. Lower-priority strobes are discarded and `monitor_error` is set.
- A strobe while the FSM is not IDLE is dropped and `monitor_error` is set (overrun). The CPU never blocks a debug strobe for more than one cycle.
- Simultaneous `cpu_read` and `cpu_write`: the write wins and the read is ignored.
- Reset while mid-operation returns the FSM to IDLE.
  - A pending RAM write is abandoned unless it has already committed on that edge.
  - RAM contents are not reset.

## Timing
- Reset values, applied on the first rising `clk` with `reset_n`=0:
  - `MonAReg`=0, `MonDReg`=0.
  - `monitor_ready`=0, `monitor_error`=0.
  - `cpu_readdata`=0, `cpu_readdatavalid`=0.
  - FSM=IDLE.
- `cpu_waitrequest` = 0 in reset, because the FSM is in IDLE.
- With a debug strobe sampled at edge E0:
  - Write: RAM commits at E1; `monitor_ready`=1 after E1.
  - Read: `MonDReg` is valid and `monitor_ready`=1 after E2.
  - Load-only: `monitor_ready`=1 after E0.
- CPU read accepted at edge E0: `cpu_readdatavalid`=1 after E1.
- RAM is single-port with synchronous read and 1-cycle latency.
- All outputs are registered except `cpu_waitrequest`.

## Configuration
- Macro `CPU_OCIMEM_PARITY_EN`.
- Defined:
  - The RAM is 33 bits wide; bit 32 holds even parity, written on every write.
  - A parity mismatch on any read, debug or CPU, sets `monitor_error`.
  - The returned data is unchanged.
- Undefined:
  - The RAM is 32 bits wide.
  - `monitor_error` reflects overrun and collision errors only.

## Structure
- Package `cpu_ocimem_pkg` holds:
  - The FSM state enum.
  - `jdo` field bit-position constants.
  - The `ADDR_W` default.
  - The parity helper function.
- Sub-module `cpu_ocimem_ram`: single-port synchronous RAM with the width selected by the macro. Behavioural, for inference.

## Test plan
- Load-only: `take_action_ocimem_a` with `jdo[33:26]`=0x10 and `jdo[35]`=0 → `monitor_ready`=1 one cycle later; `MonAReg`=0x10.
- Write then readback, starting from `MonAReg`=0x10:
  - `take_action_ocimem_b` with data 0xDEADBEEF writes address 0x10; `MonAReg` becomes 0x11.
  - Reload 0x10 with `jdo[35]`=1 → `MonDReg`=0xDEADBEEF two cycles after the strobe.
- Wrap: `MonAReg`=0xFF, then `take_no_action_ocimem_a` → read of 0xFF completes and `MonAReg`=0x00.
- Arbitration: `cpu_read` held at address 0x20 while a debug write strobe fires in the same cycle → `cpu_waitrequest`=1 for 2 cycles, then the read is accepted; `cpu_readdatavalid` pulses once, 1 cycle after acceptance.
- Overrun: a second strobe in DRD_ISSUE → dropped, `monitor_error`=1. It stays 1 until `take_action_ocimem_a` with `jdo[36]`=1.
- Parity check (`CPU_OCIMEM_PARITY_EN` defined): force-flip RAM bit 5 at address 0x30, then debug-read → `monitor_error`=1.

Source files
------------

// File: rtl/cpu_ocimem_pkg.sv
// cpu_ocimem_pkg: shared definitions for the OCI debug memory access engine.
//   - state_t       : access FSM state encoding
//   - JDO_* consts  : bit positions of the fields inside the 38-bit jdo word
//   - ADDR_W_DEF    : default word-address width (256-word RAM)
//   - RAM_W         : stored word width (33 with parity, 32 without)
//   - even_parity() : parity bit stored alongside each word
// Optional feature macro: CPU_OCIMEM_PARITY_EN (adds a parity bit per word).
package cpu_ocimem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int JDO_W      = 38;

  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_DATA_MSB = 34;
  localparam int JDO_ADDR_LSB = 26;
  localparam int JDO_ADDR_MSB = 33;
  localparam int JDO_RD_BIT   = 35;
  localparam int JDO_CLR_BIT  = 36;

`ifdef CPU_OCIMEM_PARITY_EN
  localparam int RAM_W = DATA_W_DEF + 1;
`else
  localparam int RAM_W = DATA_W_DEF;
`endif

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DRD_ISSUE = 3'd1,
    ST_DRD_CAP   = 3'd2,
    ST_DWR       = 3'd3,
    ST_CRD_CAP   = 3'd4
  } state_t;

  // Bit that makes the XOR of the stored 33-bit word zero.
  function automatic logic even_parity(input logic [DATA_W_DEF-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/cpu_ocimem_ram.sv
// cpu_ocimem_ram: single-port RAM, synchronous read with one cycle of latency.
// Behavioural so synthesis infers a block RAM. Width follows RAM_W, which
// depends on CPU_OCIMEM_PARITY_EN.
//   clk   : clock
//   we    : write enable
//   addr  : word address (shared by read and write)
//   wdata : write data
//   rdata : read data, registered (old data on a same-cycle write)
module cpu_ocimem_ram
  import cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WIDTH  = RAM_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/cpu_ocimem_access.sv
// cpu_ocimem_access: debug-side access engine for the OCI debug RAM.
// Decodes jdo plus the take_action strobes into debug RAM reads/writes and
// shares the RAM with a CPU slave port; debug traffic always has priority.
// Optional feature macro: CPU_OCIMEM_PARITY_EN (parity bit per word, parity
// mismatches on any read set monitor_error).
//   clk, reset_n                : clock, synchronous active-low reset
//   jdo                         : JTAG command/data word
//   take_action_ocimem_a        : load address, optional read (jdo[35])
//   take_action_ocimem_b        : write jdo data, then increment address
//   take_no_action_ocimem_a     : read, then increment address
//   cpu_address/read/write/
//   cpu_writedata               : CPU request
//   cpu_readdata/readdatavalid  : CPU read response (registered)
//   cpu_waitrequest             : CPU stall (combinational)
//   MonDReg                     : debug data register
//   monitor_ready/monitor_error : debug status (error is sticky)
// Handshake: a CPU request is accepted on an edge where cpu_waitrequest is 0
// and cpu_read or cpu_write is 1; writes commit on that edge, reads return on
// the following edge with cpu_readdatavalid high for exactly one cycle.
module cpu_ocimem_access
  import cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_t            state;
  logic [ADDR_W-1:0] mon_a_reg;
  logic              rd_inc;      // current debug read came from take_no_action

  logic              any_strobe;
  logic              multi_strobe;
  logic              idle;
  logic              cpu_go;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata_raw;
  logic [RAM_W-1:0]  ram_wdata;
  logic [RAM_W-1:0]  ram_rdata;
  logic              par_err;

  logic              unused_jdo;
  assign unused_jdo = ^{jdo[JDO_W-1], jdo[JDO_DATA_LSB-1:0]};

  assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b) |
                        (take_action_ocimem_a & take_no_action_ocimem_a) |
                        (take_action_ocimem_b & take_no_action_ocimem_a);
  assign idle            = (state == ST_IDLE);
  assign cpu_go          = idle & ~any_strobe;
  assign cpu_waitrequest = ~idle | any_strobe;

  // RAM port steering. Writes are suppressed while reset is asserted so an
  // in-flight debug write is abandoned rather than committed.
  always_comb begin
    ram_we        = 1'b0;
    ram_addr      = mon_a_reg;
    ram_wdata_raw = MonDReg;
    unique case (state)
      ST_DWR:  ram_we = reset_n;
      ST_IDLE: begin
        if (cpu_go) begin
          ram_addr      = cpu_address;
          ram_wdata_raw = cpu_writedata;
          ram_we        = cpu_write & reset_n;
        end
      end
      default: ;
    endcase
  end

`ifdef CPU_OCIMEM_PARITY_EN
  assign ram_wdata = {even_parity(ram_wdata_raw), ram_wdata_raw};
  assign par_err   = ^ram_rdata;
`else
  assign ram_wdata = ram_wdata_raw;
  assign par_err   = 1'b0;
`endif

  cpu_ocimem_ram #(
    .ADDR_W (ADDR_W),
    .WIDTH  (RAM_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      mon_a_reg         <= '0;
      rd_inc            <= 1'b0;
      MonDReg           <= '0;
      monitor_ready     <= 1'b0;
      monitor_error     <= 1'b0;
      cpu_readdata      <= '0;
      cpu_readdatavalid <= 1'b0;
    end else begin
      cpu_readdatavalid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (take_action_ocimem_a) begin
            mon_a_reg     <= ADDR_W'(jdo[JDO_ADDR_MSB:JDO_ADDR_LSB]);
            rd_inc        <= 1'b0;
            monitor_ready <= ~jdo[JDO_RD_BIT];
            if (jdo[JDO_RD_BIT]) state <= ST_DRD_ISSUE;
          end else if (take_action_ocimem_b) begin
            MonDReg       <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
            monitor_ready <= 1'b0;
            state         <= ST_DWR;
          end else if (take_no_action_ocimem_a) begin
            rd_inc        <= 1'b1;
            monitor_ready <= 1'b0;
            state         <= ST_DRD_ISSUE;
          end else if (cpu_read & ~cpu_write) begin
            state <= ST_CRD_CAP;
          end
          // A collision in the same cycle as a clear still reports an error.
          if (take_action_ocimem_a & jdo[JDO_CLR_BIT]) monitor_error <= 1'b0;
          if (multi_strobe) monitor_error <= 1'b1;
        end
        ST_DRD_ISSUE: state <= ST_DRD_CAP;
        ST_DRD_CAP: begin
          MonDReg       <= ram_rdata[DATA_W-1:0];
          monitor_ready <= 1'b1;
          if (rd_inc) mon_a_reg <= mon_a_reg + 1'b1;
          if (par_err) monitor_error <= 1'b1;
          state <= ST_IDLE;
        end
        ST_DWR: begin
          mon_a_reg     <= mon_a_reg + 1'b1;
          monitor_ready <= 1'b1;
          state         <= ST_IDLE;
        end
        ST_CRD_CAP: begin
          cpu_readdata      <= ram_rdata[DATA_W-1:0];
          cpu_readdatavalid <= 1'b1;
          if (par_err) monitor_error <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      // Strobes arriving while busy are dropped (overrun).
      if (!idle && any_strobe) monitor_error <= 1'b1;
    end
  end

endmodule
